ft60x_cmd_engine: RTL
=====================

# ft60x_cmd_engine

Host command engine downstream of the FT60x FIFO bridge. Consumes the 32-bit host-to-target word stream, decodes write/read command packets, and issues single-beat transactions on a simple memory request bus. Returns read data and write status words into the bridge's target-to-host stream. One transaction outstanding at a time.

## Interface
- TIMEOUT_CYCLES, 255: bus wait limit in cycles, used only when the timeout feature is compiled in; legal range 1..65535.

- clk_i  input  1  single clock for the whole block
- rst_i  input  1  synchronous, active-high reset
- inport_valid_i  input  1  host word valid (from bridge outport)
- inport_data_i  input  32  host word
- inport_accept_o  output  1  host word consumed this cycle
- outport_valid_o  output  1  response word valid (to bridge inport)
- outport_data_o  output  32  response word
- outport_accept_i  input  1  response word taken
- mem_addr_o  output  32  byte address, word aligned
- mem_data_wr_o  output  32  write data
- mem_wr_o  output  1  write request
- mem_rd_o  output  1  read request
- mem_accept_i  input  1  request accepted
- mem_ack_i  input  1  transaction complete
- mem_data_rd_i  input  32  read data, valid with mem_ack_i

## Operation
- Packet: header word, address word, then payload. Header [31:24] = cmd, [23:8] ignored, [7:0] = LEN-1 (1..256 words).
- cmd 0x01 WRITE: LEN data words follow; each written to addr, addr+4, ... After last ack, emit status 0xA501_00LL (LL = header[7:0]).
- cmd 0x02 READ: no payload; LEN reads issued; each read datum emitted as one response word; no trailing status.
- Any other cmd: header only consumed; emit 0xEE{cmd}_0000; return to HDR.
- Address increments by 4 after each ack; 32-bit wrap from 0xFFFFFFFC to 0x00000000. Remaining-count is 8-bit, decremented per ack.
- States: HDR, ADDR, WR_DATA, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, RESP, DRAIN.
  - HDR: accept word; cmd 0x01/0x02 -> ADDR, else -> RESP (error word).
  - ADDR: accept word, latch address -> WR_DATA (write) or RD_REQ (read).
  - WR_DATA: accept word, latch -> WR_REQ.
  - WR_REQ/RD_REQ: request asserted; on mem_accept_i -> WR_WAIT/RD_WAIT, or directly onward if mem_ack_i same cycle.
  - WR_WAIT: on ack, count>0 -> WR_DATA, last -> RESP (status).
  - RD_WAIT: on ack, capture mem_data_rd_i -> RESP.
  - RESP: hold word until outport_accept_i; then read with words left -> RD_REQ, else -> HDR.
  - DRAIN: accept and discard remaining write payload words, then -> RESP (timeout error).

## Timing
- Reset values: all outputs 0; state HDR; counters 0.
- inport_accept_o = inport_valid_i in HDR, ADDR, WR_DATA, DRAIN; else 0. Combinational from registered state only plus valid.
- mem_wr_o/mem_rd_o, address and write data registered; held stable until mem_accept_i; deasserted the cycle after accept.
- mem_ack_i ignored outside *_REQ/*_WAIT states. Ack may coincide with accept.
- outport_valid_o/outport_data_o registered, stable until accepted; no back-to-back within one packet (min 1 cycle RESP->RD_REQ).
- Read latency, first word: header accept to mem_rd_o = 2 cycles; ack to outport_valid_o = 1 cycle.
- Reset asserted mid-packet: partial packet discarded, strobes drop next edge; host resynchronises at next header.

## Configuration
- FT60X_CMD_TIMEOUT_EN defined: 16-bit counter clears on entry to WR_REQ/RD_REQ, counts through *_REQ/*_WAIT; at TIMEOUT_CYCLES request drops, error word 0xEE{cmd}_00RR emitted (RR = remaining count before current word); writes with payload left go through DRAIN first.
- Undefined: no counter; block waits indefinitely for accept/ack.

## Structure
- Package ft60x_cmd_pkg: cmd codes (CMD_WRITE 0x01, CMD_READ 0x02), state encoding, status prefixes (0xA5, 0xEE).
- Single module; no sub-module needed. Timeout counter inline under the macro.

## Test plan
- WRITE LEN=1 to 0x1000, data 0xDEADBEEF, mem accept+ack immediate -> one mem_wr at 0x1000, response 0xA5010000.
- READ LEN=4 from 0x20, ack returns 0x11,0x22,0x33,0x44 -> reads at 0x20..0x2C, four responses in order; outport stalled 5 cycles per word without loss.
- WRITE LEN=2 at 0xFFFFFFFC -> second write at 0x00000000; status 0xA5010001.
- Header cmd 0x7F -> only header consumed, response 0xEE7F0000, next valid packet decodes normally.
- (Timeout EN, TIMEOUT_CYCLES=8) WRITE LEN=3, mem_accept_i never -> request drops after 8 cycles, 2 payload words drained, response 0xEE010003.
- Reset during RD_WAIT -> all outputs 0 next cycle; subsequent READ LEN=1 completes correctly.

Source files
------------

// File: rtl/ft60x_cmd_pkg.sv
// Shared definitions for the FT60x host command engine: command codes,
// response word prefixes, FSM state encoding and response word builders.
// Latency: n/a (types and constants only). Backpressure: n/a.
package ft60x_cmd_pkg;

    localparam logic [7:0] CMD_WRITE  = 8'h01;
    localparam logic [7:0] CMD_READ   = 8'h02;

    localparam logic [7:0] PFX_STATUS = 8'hA5;
    localparam logic [7:0] PFX_ERROR  = 8'hEE;

    typedef enum logic [3:0] {
        ST_HDR,
        ST_ADDR,
        ST_WR_DATA,
        ST_WR_REQ,
        ST_WR_WAIT,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_RESP,
        ST_DRAIN
    } state_e;

    // Write completion: 0xA501_00LL, LL = LEN-1 from the header.
    function automatic logic [31:0] status_word(input logic [7:0] len_m1);
        return {PFX_STATUS, CMD_WRITE, 8'h00, len_m1};
    endfunction

    // Error response: 0xEE{cmd}_00RR, RR = 0 for an unknown command,
    // remaining word count for a bus timeout.
    function automatic logic [31:0] error_word(input logic [7:0] cmd,
                                               input logic [7:0] rr);
        return {PFX_ERROR, cmd, 8'h00, rr};
    endfunction

endpackage

// File: rtl/ft60x_cmd_engine_if.sv
// Bundles the three handshakes around the command engine: host word stream
// in, response word stream out, single-beat memory request bus.
// Latency/backpressure: wiring only; suffixes are from the engine's view.
// Modports: master = the engine, slave = bridge plus memory environment.
interface ft60x_cmd_engine_if;

    logic        inport_valid_i;
    logic [31:0] inport_data_i;
    logic        inport_accept_o;

    logic        outport_valid_o;
    logic [31:0] outport_data_o;
    logic        outport_accept_i;

    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_wr_o;
    logic        mem_wr_o;
    logic        mem_rd_o;
    logic        mem_accept_i;
    logic        mem_ack_i;
    logic [31:0] mem_data_rd_i;

    modport master (
        input  inport_valid_i, inport_data_i, outport_accept_i,
               mem_accept_i, mem_ack_i, mem_data_rd_i,
        output inport_accept_o, outport_valid_o, outport_data_o,
               mem_addr_o, mem_data_wr_o, mem_wr_o, mem_rd_o
    );

    modport slave (
        output inport_valid_i, inport_data_i, outport_accept_i,
               mem_accept_i, mem_ack_i, mem_data_rd_i,
        input  inport_accept_o, outport_valid_o, outport_data_o,
               mem_addr_o, mem_data_wr_o, mem_wr_o, mem_rd_o
    );

endinterface

// File: rtl/ft60x_cmd_engine.sv
// Decodes host WRITE/READ packets and runs them as single-beat memory transactions.
// Latency: header accept -> mem_rd_o 2 cycles; mem_ack_i -> outport_valid_o 1 cycle.
// Backpressure: one transaction outstanding; input stalls outside HDR/ADDR/WR_DATA/DRAIN.
module ft60x_cmd_engine
    import ft60x_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inport_valid_i,
    input  logic [31:0] inport_data_i,
    output logic        inport_accept_o,
    output logic        outport_valid_o,
    output logic [31:0] outport_data_o,
    input  logic        outport_accept_i,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_wr_o,
    output logic        mem_wr_o,
    output logic        mem_rd_o,
    input  logic        mem_accept_i,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_rd_i
);

    state_e      state_q, state_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        more_q, more_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        mem_wr_q, mem_wr_d;
    logic        mem_rd_q, mem_rd_d;
    logic        out_vld_q, out_vld_d;
    logic [31:0] out_dat_q, out_dat_d;

    logic        in_acc;
    logic        wr_done;
    logic        rd_done;
    logic [15:0] hdr_unused;

    assign hdr_unused = inport_data_i[23:8];

    assign in_acc = inport_valid_i &&
                    ((state_q == ST_HDR) || (state_q == ST_ADDR) ||
                     (state_q == ST_WR_DATA) || (state_q == ST_DRAIN));

    assign wr_done = ((state_q == ST_WR_REQ) && mem_accept_i && mem_ack_i) ||
                     ((state_q == ST_WR_WAIT) && mem_ack_i);
    assign rd_done = ((state_q == ST_RD_REQ) && mem_accept_i && mem_ack_i) ||
                     ((state_q == ST_RD_WAIT) && mem_ack_i);

`ifdef FT60X_CMD_TIMEOUT_EN
    logic [15:0] to_q, to_d;
    logic        bus_phase;
    logic        to_hit;

    assign bus_phase = (state_q == ST_WR_REQ) || (state_q == ST_WR_WAIT) ||
                       (state_q == ST_RD_REQ) || (state_q == ST_RD_WAIT);
    assign to_d   = bus_phase ? (to_q + 16'd1) : 16'd0;
    assign to_hit = bus_phase && !wr_done && !rd_done &&
                    (to_q == 16'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        more_d    = more_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        mem_wr_d  = mem_wr_q;
        mem_rd_d  = mem_rd_q;
        out_vld_d = out_vld_q;
        out_dat_d = out_dat_q;

        case (state_q)
            ST_HDR: begin
                if (in_acc) begin
                    cmd_d  = inport_data_i[31:24];
                    len_d  = inport_data_i[7:0];
                    cnt_d  = inport_data_i[7:0];
                    more_d = 1'b0;
                    if ((inport_data_i[31:24] == CMD_WRITE) ||
                        (inport_data_i[31:24] == CMD_READ)) begin
                        state_d = ST_ADDR;
                    end else begin
                        out_vld_d = 1'b1;
                        out_dat_d = error_word(inport_data_i[31:24], 8'h00);
                        state_d   = ST_RESP;
                    end
                end
            end

            ST_ADDR: begin
                if (in_acc) begin
                    addr_d = {inport_data_i[31:2], 2'b00};
                    if (cmd_q == CMD_WRITE) begin
                        state_d = ST_WR_DATA;
                    end else begin
                        mem_rd_d = 1'b1;
                        state_d  = ST_RD_REQ;
                    end
                end
            end

            ST_WR_DATA: begin
                if (in_acc) begin
                    wdata_d  = inport_data_i;
                    mem_wr_d = 1'b1;
                    state_d  = ST_WR_REQ;
                end
            end

            ST_WR_REQ, ST_WR_WAIT: begin
                if ((state_q == ST_WR_REQ) && mem_accept_i) begin
                    mem_wr_d = 1'b0;
                    state_d  = ST_WR_WAIT;
                end
                if (wr_done) begin
                    addr_d = addr_q + 32'd4;
                    if (cnt_q == 8'd0) begin
                        out_vld_d = 1'b1;
                        out_dat_d = status_word(len_q);
                        state_d   = ST_RESP;
                    end else begin
                        cnt_d   = cnt_q - 8'd1;
                        state_d = ST_WR_DATA;
                    end
                end
            end

            ST_RD_REQ, ST_RD_WAIT: begin
                if ((state_q == ST_RD_REQ) && mem_accept_i) begin
                    mem_rd_d = 1'b0;
                    state_d  = ST_RD_WAIT;
                end
                if (rd_done) begin
                    addr_d    = addr_q + 32'd4;
                    out_vld_d = 1'b1;
                    out_dat_d = mem_data_rd_i;
                    more_d    = (cnt_q != 8'd0);
                    if (cnt_q != 8'd0) begin
                        cnt_d = cnt_q - 8'd1;
                    end
                    state_d = ST_RESP;
                end
            end

            ST_RESP: begin
                if (outport_accept_i) begin
                    out_vld_d = 1'b0;
                    if (more_q) begin
                        mem_rd_d = 1'b1;
                        state_d  = ST_RD_REQ;
                    end else begin
                        state_d = ST_HDR;
                    end
                end
            end

            ST_DRAIN: begin
                if (in_acc) begin
                    if (cnt_q <= 8'd1) begin
                        cnt_d     = 8'd0;
                        out_vld_d = 1'b1;
                        state_d   = ST_RESP;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end

            default: state_d = ST_HDR;
        endcase

`ifdef FT60X_CMD_TIMEOUT_EN
        if (to_hit) begin
            mem_wr_d  = 1'b0;
            mem_rd_d  = 1'b0;
            more_d    = 1'b0;
            out_dat_d = error_word(cmd_q, cnt_q + 8'd1);
            if (((state_q == ST_WR_REQ) || (state_q == ST_WR_WAIT)) && (cnt_q != 8'd0)) begin
                state_d = ST_DRAIN;
            end else begin
                out_vld_d = 1'b1;
                state_d   = ST_RESP;
            end
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_HDR;
            cmd_q     <= 8'h00;
            len_q     <= 8'h00;
            cnt_q     <= 8'h00;
            more_q    <= 1'b0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            mem_wr_q  <= 1'b0;
            mem_rd_q  <= 1'b0;
            out_vld_q <= 1'b0;
            out_dat_q <= 32'h0;
`ifdef FT60X_CMD_TIMEOUT_EN
            to_q      <= 16'h0;
`endif
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            more_q    <= more_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            mem_wr_q  <= mem_wr_d;
            mem_rd_q  <= mem_rd_d;
            out_vld_q <= out_vld_d;
            out_dat_q <= out_dat_d;
`ifdef FT60X_CMD_TIMEOUT_EN
            to_q      <= to_d;
`endif
        end
    end

    assign inport_accept_o = in_acc;
    assign outport_valid_o = out_vld_q;
    assign outport_data_o  = out_dat_q;
    assign mem_addr_o      = addr_q;
    assign mem_data_wr_o   = wdata_q;
    assign mem_wr_o        = mem_wr_q;
    assign mem_rd_o        = mem_rd_q;

endmodule
